// File: rtl/adc128s_spi_model_if.sv
// SPI link between the A2D interface (master) and the ADC128S model (slave).
//   SS_n : slave select, active low; one frame per low period
//   SCLK : serial clock driven by the master
//   MOSI : command bits from the master, MSB first
//   MISO : conversion data back to the master, MSB first
interface adc128s_spi_model_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/adc128s_spi_model.sv
// Synthesizable model of an 8-channel 12-bit SPI A2D converter (ADC128S-style).
// The channel addressed in frame N is returned MSB-first in frame N+1 as
// {4'h0, data[11:0]}.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   spi          : SPI slave port (SS_n, SCLK, MOSI in; MISO out)
//   ld_cell_lft  : channel 0 value
//   ld_cell_rght : channel 4 value
//   steerPot     : channel 5 value
//   batt         : channel 6 value
//   update_ch    : one-clk pulse when a frame ends and a new result is latched
module adc128s_spi_model (
    input  logic                      clk,
    input  logic                      rst_n,
    adc128s_spi_model_if.slave        spi,
    input  logic [11:0]               ld_cell_lft,
    input  logic [11:0]               ld_cell_rght,
    input  logic [11:0]               steerPot,
    input  logic [11:0]               batt,
    output logic                      update_ch
);

    localparam int unsigned DATA_W = 12;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned CH_W   = 3;
    // Only bits [13:11] are ever decoded, so the top two bits of the 16-bit
    // receive word would never be read.
    localparam int unsigned RX_W   = 14;

    typedef enum logic {
        ST_IDLE,
        ST_FRAME
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          ss_sync_q;
    logic [2:0]          sclk_sync_q;
    logic [1:0]          mosi_sync_q;
    logic [RX_W-1:0]     rx_q, rx_d;
    logic [WORD_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                update_q, update_d;

    logic                ss_fall;
    logic                ss_rise;
    logic                sclk_rise;
    logic [CH_W-1:0]     ch_sel;
    logic [DATA_W-1:0]   ch_data;

    // Two-flop synchronizers plus a third flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync_q   <= 3'b111;
            sclk_sync_q <= 3'b111;
            mosi_sync_q <= 2'b00;
        end else begin
            ss_sync_q   <= {ss_sync_q[1:0], spi.SS_n};
            sclk_sync_q <= {sclk_sync_q[1:0], spi.SCLK};
            mosi_sync_q <= {mosi_sync_q[0], spi.MOSI};
        end
    end

    assign ss_fall   = ss_sync_q[2] & ~ss_sync_q[1];
    assign ss_rise   = ~ss_sync_q[2] & ss_sync_q[1];
    assign sclk_rise = ~sclk_sync_q[2] & sclk_sync_q[1];

    // Channel decode from the last command bits received
    assign ch_sel = rx_q[13:11];

    always_comb begin
        ch_data = DATA_W'(0);
        case (ch_sel)
            3'd0:    ch_data = ld_cell_lft;
            3'd4:    ch_data = ld_cell_rght;
            3'd5:    ch_data = steerPot;
            3'd6:    ch_data = batt;
            default: ch_data = DATA_W'(0);
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rx_q     <= RX_W'(0);
            tx_q     <= WORD_W'(0);
            result_q <= DATA_W'(0);
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rx_q     <= rx_d;
            tx_q     <= tx_d;
            result_q <= result_d;
            update_q <= update_d;
        end
    end

    // Frame sequencing: load on SS_n fall, shift on SCLK rise, latch on SS_n rise
    always_comb begin
        state_d  = state_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        result_d = result_q;
        update_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    tx_d    = {4'h0, result_q};
                    state_d = ST_FRAME;
                end
            end
            ST_FRAME: begin
                if (ss_rise) begin
                    result_d = ch_data;
                    update_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (sclk_rise) begin
                    // Master already sampled MISO on this rise; advance both words.
                    rx_d = {rx_q[RX_W-2:0], mosi_sync_q[1]};
                    tx_d = {tx_q[WORD_W-2:0], 1'b0};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign spi.MISO  = tx_q[WORD_W-1];
    assign update_ch = update_q;

endmodule

// File: tb/tb_adc128s_spi_model.sv
// Self-checking bench for adc128s_spi_model: table of command frames with
// expected readback, hand-written corner sequences, and randomized frames
// checked against a frame-level reference model.
module tb_adc128s_spi_model;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] lft, rght, steer, batt;
    logic        update_ch;

    adc128s_spi_model_if spi();

    adc128s_spi_model dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi         (spi),
        .ld_cell_lft (lft),
        .ld_cell_rght(rght),
        .steerPot    (steer),
        .batt        (batt),
        .update_ch   (update_ch)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int upd_cnt = 0;

    always @(posedge clk) if (update_ch === 1'b1) upd_cnt <= upd_cnt + 1;

    // Reference model: value latched at the end of the last frame
    logic [11:0] m_latched = 12'h000;

    typedef struct {
        logic [15:0] cmd;
        logic [11:0] lft;
        logic [11:0] rght;
        logic [11:0] steer;
        logic [11:0] batt;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [11:0] ref_val(input logic [15:0] cmd);
        int ch;
        ch = int'(cmd[13:11]);
        if (ch == 0) return lft;
        if (ch == 4) return rght;
        if (ch == 5) return steer;
        if (ch == 6) return batt;
        return 12'h000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One SPI frame, SCLK idle low, nbits rises; word[nbits-1] sent first.
    task automatic run_frame(input logic [31:0] word, input int nbits,
                             input logic [15:0] exp, input string name);
        logic [15:0] rx;
        int          c0;
        rx = 16'h0;
        c0 = upd_cnt;
        spi.SS_n = 1'b0;
        repeat (6) tick();
        for (int i = nbits - 1; i >= 0; i--) begin
            spi.MOSI = word[i];
            repeat (4) tick();
            if (nbits - 1 - i < 16) rx = {rx[14:0], spi.MISO};
            spi.SCLK = 1'b1;
            repeat (4) tick();
            spi.SCLK = 1'b0;
        end
        repeat (6) tick();
        spi.SS_n = 1'b1;
        repeat (8) tick();
        check({name, " word"}, 32'(rx), 32'(exp));
        check({name, " update_ch pulses"}, 32'(upd_cnt - c0), 32'd1);
        m_latched = ref_val(word[15:0]);
    endtask

    initial begin
        int c0;
        logic [15:0] cmd;

        spi.SS_n = 1'b1;
        spi.SCLK = 1'b0;
        spi.MOSI = 1'b0;
        lft = 12'h3A5; rght = 12'h000; steer = 12'h000; batt = 12'h000;

        // Reset state
        repeat (3) tick();
        check("reset MISO", 32'(spi.MISO), 32'd0);
        check("reset update_ch", 32'(update_ch), 32'd0);
        rst_n = 1'b1;
        repeat (6) tick();
        check("post-reset update_ch count", 32'(upd_cnt), 32'd0);

        //             cmd       lft      rght     steer    batt     exp
        tbl[0]  = '{16'h0000, 12'h3A5, 12'h000, 12'h000, 12'h000, 16'h0000};
        tbl[1]  = '{16'h2000, 12'h3A5, 12'h000, 12'h000, 12'h000, 16'h03A5};
        tbl[2]  = '{16'h0000, 12'h111, 12'h222, 12'h333, 12'hC00, 16'h0000};
        tbl[3]  = '{16'h2000, 12'h111, 12'h222, 12'h333, 12'hC00, 16'h0111};
        tbl[4]  = '{16'h2800, 12'h111, 12'h222, 12'h333, 12'hC00, 16'h0222};
        tbl[5]  = '{16'h3000, 12'h111, 12'h222, 12'h333, 12'hC00, 16'h0333};
        tbl[6]  = '{16'h1000, 12'h111, 12'h222, 12'h333, 12'h800, 16'h0C00};
        tbl[7]  = '{16'h0000, 12'h111, 12'h222, 12'h333, 12'h800, 16'h0000};
        tbl[8]  = '{16'h3800, 12'h111, 12'h222, 12'h333, 12'h800, 16'h0111};
        tbl[9]  = '{16'h0800, 12'h111, 12'h222, 12'h333, 12'h800, 16'h0000};
        tbl[10] = '{16'hE7FF, 12'h111, 12'h222, 12'h333, 12'h800, 16'h0000};
        tbl[11] = '{16'h0000, 12'h111, 12'h222, 12'h333, 12'h800, 16'h0222};

        for (int k = 0; k < 12; k++) begin
            lft = tbl[k].lft; rght = tbl[k].rght; steer = tbl[k].steer; batt = tbl[k].batt;
            run_frame(32'(tbl[k].cmd), 16, tbl[k].exp, $sformatf("table[%0d]", k));
        end

        // Over-length frame: last 16 bits select ch5
        run_frame(32'h000F_2800, 20, 16'h0111, "long frame");
        run_frame(32'h0000_0000, 16, 16'h0333, "long frame readback");

        // SCLK toggling with SS_n high must not shift anything
        spi.MOSI = 1'b1;
        for (int i = 0; i < 6; i++) begin
            spi.SCLK = 1'b1; repeat (4) tick();
            spi.SCLK = 1'b0; repeat (4) tick();
        end
        check("idle SCLK update_ch", 32'(update_ch), 32'd0);
        run_frame(32'h0000_2800, 16, 16'h0111, "after idle SCLK");
        run_frame(32'h0000_0000, 16, 16'h0333, "after idle SCLK readback");

        // Reset mid-frame after 7 SCLK rises; latched word is 16'h0111
        spi.SS_n = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < 7; i++) begin
            spi.MOSI = 1'b1;
            repeat (4) tick();
            spi.SCLK = 1'b1; repeat (4) tick();
            spi.SCLK = 1'b0;
        end
        repeat (4) tick();
        check("mid-frame MISO before reset", 32'(spi.MISO), 32'd1);
        c0 = upd_cnt;
        rst_n = 1'b0;
        #1;
        check("mid-frame reset MISO", 32'(spi.MISO), 32'd0);
        spi.SS_n = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("mid-frame reset update_ch", 32'(upd_cnt - c0), 32'd0);
        m_latched = 12'h000;
        run_frame(32'h0000_0000, 16, 16'h0000, "post-reset frame");

        // Randomized frames against the reference model
        for (int k = 0; k < 40; k++) begin
            lft   = 12'($urandom);
            rght  = 12'($urandom);
            steer = 12'($urandom);
            batt  = 12'($urandom);
            cmd   = 16'($urandom);
            run_frame(32'(cmd), 16, {4'h0, m_latched}, $sformatf("random[%0d]", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule

// File: doc/adc128s_spi_model.md
Name: adc128s_spi_model

Overview:
- Behavioural/synthesizable model of an 8-channel, 12-bit SPI A2D converter (ADC128S-style) used in the Segway system bench.
- The Segway controller's A2D interface drives it as SPI master.
- Four analog quantities are supplied as 12-bit digital inputs: left/right load cells, steering pot and battery.
- The model returns the value of the channel addressed in the previous SPI frame.

Parameters:
- none

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- SS_n  input  1  SPI slave select, active low; frame = low period
- SCLK  input  1  SPI serial clock from master; frequency ≤ clk/8
- MOSI  input  1  SPI data from master
- MISO  output  1  SPI data to master, MSB first
- ld_cell_lft  input  12  value reported on channel 0
- ld_cell_rght  input  12  value reported on channel 4
- steerPot  input  12  value reported on channel 5
- batt  input  12  value reported on channel 6
- update_ch  output  1  one-clk pulse when a frame completes and a new channel/result is latched

Behaviour:
- Input sync: SS_n, SCLK and MOSI each pass through a 2-flop synchronizer, plus a third flop for edge detect.
  - SS_n and SCLK sync flops reset to 1; MOSI flops reset to 0.
- Frame start (synced SS_n 1→0): tx_shft[15:0] <= {4'h0, result[11:0]}.
- SCLK rising edge (synced) while SS_n low:
  - rx_shft <= {rx_shft[14:0], MOSI_synced}
  - tx_shft <= {tx_shft[14:0], 1'b0}
  - Both shifts occur in the same clk.
  - Master samples MISO on its SCLK rise, before the model's synchronized shift, so bit 15 is seen on the first rise. This holds for SCLK idle-high or idle-low masters.
- MISO = tx_shft[15] at all times, registered. No tristate.
- Frame end (synced SS_n 0→1):
  - chnl[2:0] <= rx_shft[13:11]
  - result <= mux(rx_shft[13:11]) of the inputs sampled in that clk
  - update_ch = 1 for exactly that one clk
- Channel map:
  - 0 → ld_cell_lft
  - 4 → ld_cell_rght
  - 5 → steerPot
  - 6 → batt
  - 1, 2, 3, 7 → 12'h000
- Latency: the data for the channel addressed in frame N is returned MSB-first in frame N+1, as bits [11:0] of the 16-bit word. Bits [15:12] read 0.
- Input changes after frame N ends do not affect the frame N+1 data.
- Frame length: nominally 16 SCLK rises.
  - More than 16: extra rises keep shifting; the last 16 MOSI bits define the channel.
  - Fewer than 16: rx_shft holds whatever was shifted; channel is still taken from rx_shft[13:11].
  - rx_shft is not cleared at frame start. Frames with <16 bits decode from mixed history; not supported by the master.
- SCLK edges while SS_n high: ignored; no shifting.
- Timing requirement on master: ≥4 clk between SS_n fall and first SCLK edge, and ≥4 clk between last SCLK rise and SS_n rise.
- Reset (async, any time, including mid-frame):
  - chnl=0, result=0, tx_shft=0, rx_shft=0, update_ch=0, MISO=0
  - A partially received frame is discarded.
  - After reset the first frame returns 16'h0000.
- update_ch never asserts on SS_n transitions caused by reset release.

Test Plan:
- Reset then frame with MOSI=16'h0000 (ch0), ld_cell_lft=12'h3A5: MISO word 16'h0000; update_ch pulses once at SS_n rise. Next frame MOSI=16'h2000 (ch4) returns 16'h03A5.
- Round-robin ch0,4,5,6 with lft=12'h111, rght=12'h222, steer=12'h333, batt=12'hC00: the four successive frames return 16'h0111, 16'h0222, 16'h0333, 16'h0C00.
- Address ch2 (MOSI 16'h1000), then any frame: returns 16'h0000.
- Change batt from 12'hC00 to 12'h800 after the ch6 command frame ends but before the readback frame: the readback returns 16'h0C00, not 16'h0800.
- Assert rst_n low mid-frame after 7 SCLK rises: MISO=0 immediately and update_ch stays 0. The next full frame returns 16'h0000.
- Toggle SCLK with SS_n high, then a normal frame: tx/rx contents unaffected; the returned word matches the previously latched result.
